// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes core loads/stores onto a word RAM and a small
// peripheral page (LED, cycle counter, console TX FIFO, sticky status).
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 128,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [15:0] LEDOut,
    output logic [7:0]  ConsoleData,
    output logic        ConsoleValid,
    input  logic        ConsoleReady
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [29:0] IO_WORD   = IO_BASE[31:2];
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_ram [DEPTH_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [15:0]   r_led;
    logic [31:0]   r_cnt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_ovf;
    logic          r_buserr;

    logic [29:0]   w_word;
    logic [AW-1:0] w_ram_idx;
    logic          w_sel_ram, w_sel_led, w_sel_cnt, w_sel_tx, w_sel_stat, w_unmapped;
    logic          w_empty, w_full, w_pop, w_push_req, w_push, w_ovf_set, w_buserr_set;
    logic [31:0]   w_stat;

    // Address decode works on the word address; Addr[1:0] never matters.
    assign w_word     = Addr[31:2];
    assign w_ram_idx  = Addr[AW+1:2];
    assign w_sel_ram  = (Addr < RAM_BYTES);
    assign w_sel_led  = (w_word == IO_WORD);
    assign w_sel_cnt  = (w_word == IO_WORD + 30'd1);
    assign w_sel_tx   = (w_word == IO_WORD + 30'd2);
    assign w_sel_stat = (w_word == IO_WORD + 30'd3);
    assign w_unmapped = !(w_sel_ram || w_sel_led || w_sel_cnt || w_sel_tx || w_sel_stat);

    // Console handshake: a byte transfers on a rising CLK edge where
    // ConsoleValid && ConsoleReady; ConsoleData is the head entry while valid.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FIFO_FULL);
    assign w_pop        = !w_empty && ConsoleReady;
    assign w_push_req   = MemWrite && w_sel_tx;
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_ovf_set    = w_push_req && w_full && !w_pop;
    assign w_buserr_set = MemWrite && w_unmapped;

    assign ConsoleValid = !w_empty;
    assign ConsoleData  = w_empty ? 8'h00 : r_fifo[r_rptr];
    assign LEDOut       = r_led;
    assign w_stat       = {28'b0, r_buserr, r_ovf, w_full, w_empty};

    always_comb begin
        ReadData = 32'h0;
        if (w_sel_ram)       ReadData = r_ram[w_ram_idx];
        else if (w_sel_led)  ReadData = {16'h0, r_led};
        else if (w_sel_cnt)  ReadData = r_cnt;
        else if (w_sel_tx)   ReadData = 32'(r_count);
        else if (w_sel_stat) ReadData = w_stat;
    end

    // Storage arrays carry no reset; reset still blocks a same-cycle write.
    always_ff @(posedge CLK) begin
        if (Reset && MemWrite && w_sel_ram) r_ram[w_ram_idx] <= WriteData;
        if (Reset && w_push)                r_fifo[r_wptr]   <= WriteData[7:0];
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_led    <= '0;
            r_cnt    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_buserr <= 1'b0;
        end else begin
            if (MemWrite && w_sel_led) r_led <= WriteData[15:0];
            r_cnt <= (MemWrite && w_sel_cnt) ? WriteData : r_cnt + 32'd1;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A set raised by this access outranks a write-one-to-clear.
            if (w_ovf_set)                                  r_ovf <= 1'b1;
            else if (MemWrite && w_sel_stat && WriteData[2]) r_ovf <= 1'b0;
            if (w_buserr_set)                                r_buserr <= 1'b1;
            else if (MemWrite && w_sel_stat && WriteData[3]) r_buserr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, counter, console FIFO, status, decode.
module tb_data_mem_responder;

    localparam logic [31:0] IO      = 32'hFFFF_FF00;
    localparam logic [31:0] IO_LED  = IO + 32'h00;
    localparam logic [31:0] IO_CNT  = IO + 32'h04;
    localparam logic [31:0] IO_TX   = IO + 32'h08;
    localparam logic [31:0] IO_STAT = IO + 32'h0C;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] LEDOut;
    logic [7:0]  ConsoleData;
    logic        ConsoleValid;
    logic        ConsoleReady;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .MemWrite     (MemWrite),
        .Addr         (Addr),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .LEDOut       (LEDOut),
        .ConsoleData  (ConsoleData),
        .ConsoleValid (ConsoleValid),
        .ConsoleReady (ConsoleReady)
    );

    always #5 CLK = ~CLK;

    // Drivers: called at a falling edge; a write spans one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a; WriteData = d; MemWrite = 1'b1;
        @(negedge CLK);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a; MemWrite = 1'b0;
        #1 d = ReadData;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (LEDOut !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", LEDOut); end
        checks++; if (ConsoleValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ConsoleValid); end
        checks++; if (ConsoleData !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", ConsoleData); end
        rd(IO_STAT, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_stat got %h exp 00000001", v); end
        rd(IO_CNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 00000000", v); end
        Reset = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(32'h10, 32'hDEADBEEF);
        rd(32'h10, v);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_10 got %h exp deadbeef", v); end
        rd(32'h13, v);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_13 got %h exp deadbeef", v); end
        wr(32'h1FC, 32'hA5A5_5A5A);
        rd(32'h1FC, v);
        checks++; if (v !== 32'hA5A5_5A5A) begin errors++; $display("FAIL ram_top got %h exp a5a55a5a", v); end
        rd(32'h10, v);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_keep got %h exp deadbeef", v); end
        rd(32'h200, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ram_past_end got %h exp 00000000", v); end
        @(negedge CLK);
    endtask

    task automatic test_read_during_write();
        wr(32'h20, 32'd5);
        Addr = 32'h20; WriteData = 32'd9; MemWrite = 1'b1;
        #1;
        checks++; if (ReadData !== 32'd5) begin errors++; $display("FAIL rdw_old got %h exp 00000005", ReadData); end
        @(negedge CLK);
        MemWrite = 1'b0;
        #1;
        checks++; if (ReadData !== 32'd9) begin errors++; $display("FAIL rdw_new got %h exp 00000009", ReadData); end
        @(negedge CLK);
    endtask

    task automatic test_counter();
        logic [31:0] v;
        wr(IO_CNT, 32'hFFFF_FFFE);
        rd(IO_CNT, v);
        checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cnt_load got %h exp fffffffe", v); end
        @(negedge CLK); rd(IO_CNT, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_max got %h exp ffffffff", v); end
        @(negedge CLK); rd(IO_CNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h exp 00000000", v); end
        @(negedge CLK);
        wr(IO_CNT, 32'h100);
        rd(IO_CNT, v);
        checks++; if (v !== 32'h100) begin errors++; $display("FAIL cnt_prio got %h exp 00000100", v); end
        @(negedge CLK); rd(IO_CNT, v);
        checks++; if (v !== 32'h101) begin errors++; $display("FAIL cnt_inc got %h exp 00000101", v); end
        @(negedge CLK);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] v;
        ConsoleReady = 1'b0;
        Addr = IO_TX; WriteData = 32'h41; MemWrite = 1'b1;
        #1;
        checks++; if (ConsoleValid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", ConsoleValid); end
        @(negedge CLK);
        MemWrite = 1'b0;
        checks++; if (ConsoleValid !== 1'b1 || ConsoleData !== 8'h41) begin errors++; $display("FAIL first_push got %b/%h exp 1/41", ConsoleValid, ConsoleData); end
        for (int i = 1; i < 8; i++) wr(IO_TX, 32'h41 + 32'(i));
        rd(IO_STAT, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL stat_full got %h exp 00000002", v); end
        rd(IO_TX, v);
        checks++; if (v !== 32'd8) begin errors++; $display("FAIL tx_count8 got %h exp 00000008", v); end
        wr(IO_TX, 32'h49);
        rd(IO_STAT, v);
        checks++; if (v !== 32'h6) begin errors++; $display("FAIL stat_ovf got %h exp 00000006", v); end
        rd(IO_TX, v);
        checks++; if (v !== 32'd8) begin errors++; $display("FAIL tx_count_ovf got %h exp 00000008", v); end
        ConsoleReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (ConsoleValid !== 1'b1 || ConsoleData !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL drain_%0d got %b/%h exp 1/%h", i, ConsoleValid, ConsoleData, 8'(8'h41 + i));
            end
            @(negedge CLK);
        end
        checks++; if (ConsoleValid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", ConsoleValid); end
        ConsoleReady = 1'b0;
        wr(IO_STAT, 32'h4);
        rd(IO_STAT, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL ovf_clear got %h exp 00000001", v); end
        @(negedge CLK);
    endtask

    task automatic test_full_with_pop();
        logic [31:0] v;
        logic [7:0]  exp_seq [8];
        ConsoleReady = 1'b0;
        for (int i = 0; i < 8; i++) wr(IO_TX, 32'h60 + 32'(i));
        Addr = IO_TX; WriteData = 32'h50; MemWrite = 1'b1; ConsoleReady = 1'b1;
        @(negedge CLK);
        MemWrite = 1'b0; ConsoleReady = 1'b0;
        rd(IO_TX, v);
        checks++; if (v !== 32'd8) begin errors++; $display("FAIL fullpop_count got %h exp 00000008", v); end
        rd(IO_STAT, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL fullpop_stat got %h exp 00000002", v); end
        exp_seq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h50};
        ConsoleReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (ConsoleValid !== 1'b1 || ConsoleData !== exp_seq[i]) begin
                errors++; $display("FAIL fullpop_drain_%0d got %b/%h exp 1/%h", i, ConsoleValid, ConsoleData, exp_seq[i]);
            end
            @(negedge CLK);
        end
        checks++; if (ConsoleValid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", ConsoleValid); end
        ConsoleReady = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        ConsoleReady = 1'b0;
        wr(IO_TX, 32'h70);
        Addr = IO_TX; WriteData = 32'h71; MemWrite = 1'b1; ConsoleReady = 1'b1;
        @(negedge CLK);
        MemWrite = 1'b0; ConsoleReady = 1'b0;
        rd(IO_TX, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL b2b_count got %h exp 00000001", v); end
        checks++; if (ConsoleData !== 8'h71) begin errors++; $display("FAIL b2b_head got %h exp 71", ConsoleData); end
        ConsoleReady = 1'b1;
        @(negedge CLK);
        ConsoleReady = 1'b0;
        checks++; if (ConsoleValid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", ConsoleValid); end
    endtask

    task automatic test_unmapped_and_led();
        logic [31:0] v;
        wr(IO + 32'h10, 32'h1234);
        rd(IO + 32'h10, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 00000000", v); end
        rd(IO_STAT, v);
        checks++; if (v !== 32'h9) begin errors++; $display("FAIL buserr_set got %h exp 00000009", v); end
        wr(IO_STAT, 32'h0);
        rd(IO_STAT, v);
        checks++; if (v !== 32'h9) begin errors++; $display("FAIL stat_write0 got %h exp 00000009", v); end
        wr(IO_STAT, 32'h8);
        rd(IO_STAT, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL buserr_clear got %h exp 00000001", v); end
        wr(IO_LED, 32'h12345);
        checks++; if (LEDOut !== 16'h2345) begin errors++; $display("FAIL led_out got %h exp 2345", LEDOut); end
        rd(IO_LED, v);
        checks++; if (v !== 32'h2345) begin errors++; $display("FAIL led_read got %h exp 00002345", v); end
        @(negedge CLK);
    endtask

    task automatic test_reset_midop();
        logic [31:0] v;
        ConsoleReady = 1'b0;
        wr(IO_TX, 32'h33);
        wr(IO_TX, 32'h34);
        Reset = 1'b0;
        Addr = IO_LED; WriteData = 32'hBEEF; MemWrite = 1'b1;
        @(negedge CLK);
        MemWrite = 1'b0; Reset = 1'b1;
        checks++; if (ConsoleValid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", ConsoleValid); end
        checks++; if (LEDOut !== 16'h0) begin errors++; $display("FAIL midrst_led got %h exp 0000", LEDOut); end
        rd(IO_TX, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_count got %h exp 00000000", v); end
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0; ConsoleReady = 1'b0;
        test_reset();
        test_ram();
        test_read_during_write();
        test_counter();
        test_fifo_overflow();
        test_full_with_pop();
        test_back_to_back();
        test_unmapped_and_led();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder side of the core's data-memory port. It decodes each core access (Addr, WriteData, MemWrite) onto two targets: a word-addressed data RAM and a small memory-mapped peripheral page. The page holds an LED register, a free-running cycle counter, and a console TX FIFO that drains over a valid/ready byte interface. Reads are combinational in the same cycle, because the core samples ReadData at the end of its Memory stage; all writes commit on the rising clock edge.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words in the data RAM (power of 2)
FIFO_DEPTH, 8, console FIFO entries (power of 2, at least 2)
IO_BASE, 32'hFFFF_FF00, base address of the peripheral page

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous reset, active-low
MemWrite  in  1  core write strobe, Memory stage
Addr  in  32  byte address (core OpResult)
WriteData  in  32  store data
ReadData  out  32  load data, combinational from Addr
LEDOut  out  16  LED register bits [15:0]
ConsoleData  out  8  FIFO head byte
ConsoleValid  out  1  FIFO not empty
ConsoleReady  in  1  sink accepts byte

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: it acts on a CLK edge where Reset==0.
- Reset values:
  - LEDOut=0, counter=0.
  - FIFO empty: ConsoleValid=0, ConsoleData=0.
  - All sticky status bits 0.
  - RAM contents are not reset.
- Reset asserted mid-operation discards FIFO contents and overrides any same-cycle write.
- Address decode ignores Addr[1:0]; all accesses are whole words.
  - RAM region: Addr < DEPTH_WORDS*4, index = Addr[log2(DEPTH_WORDS)+1:2].
  - IO+0x00 LED: read {16'b0, LEDOut}; write loads WriteData[15:0].
  - IO+0x04 CNT: read counter. The counter increments every cycle and wraps from 2^32-1 to 0. A write loads WriteData, and the load takes priority over the increment that cycle.
  - IO+0x08 TX: a write pushes WriteData[7:0]. A read returns the FIFO occupancy count, zero-extended.
  - IO+0x0C STAT (read bits): bit0 empty, bit1 full, bit2 overflow (sticky), bit3 bus error (sticky), other bits 0. Writing 1 to bit2 or bit3 clears that bit; writing 0 leaves it unchanged.
  - Any other address is unmapped: reads return 0; writes are ignored and set bus error.
- RAM read-during-write to the same word returns the old word in that cycle. The new word is visible from the next cycle.
- FIFO:
  - Circular buffer with separate read and write pointers plus a count from 0 to FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - Pop happens when ConsoleValid && ConsoleReady at the clock edge. ConsoleData always equals the head entry while ConsoleValid=1.
  - Push when not full: accepted, count+1.
  - Push when full with a simultaneous pop: accepted, count unchanged, no overflow.
  - Push when full with no pop: byte dropped, overflow set, count unchanged.
  - Push when empty: the byte appears on ConsoleData with ConsoleValid=1 in the next cycle. There is no combinational bypass.
  - Pop and push in the same cycle at count 1: count stays 1 and the head becomes the pushed byte.
- Latency: reads take 0 cycles. A write becomes visible 1 cycle later.
- A write strobe together with a same-cycle clear of a sticky bit: a set caused by the current access wins over the clear.
- MemWrite=0 with any Addr has no side effects. Reads never pop the FIFO and never clear status bits.

Test Plan:
- Reset and RAM:
  - Hold Reset=0 for 2 cycles -> LEDOut=0, ConsoleValid=0, STAT read = 32'h1.
  - Then write 32'hDEADBEEF to 0x10 and read 0x10 (also read via 0x13) -> both return DEADBEEF.
  - Then write 0x1FC and read it back -> the value written.
- Read-during-write:
  - With MemWrite=1 to 0x20 (old value 5, new value 9), ReadData that cycle = 5; the next cycle returns 9.
- Counter:
  - Write CNT=32'hFFFFFFFE, then read on the following two cycles -> FFFFFFFF, then 0 (wrap).
  - A write to CNT on the same cycle as the increment -> the loaded value wins.
- FIFO fill and overflow:
  - Hold ConsoleReady=0 and push 0x41..0x48 (8 bytes) -> STAT bit1=1, TX read=8.
  - A 9th push of 0x49 -> dropped, STAT bit2=1.
  - Raise ConsoleReady -> bytes drain 0x41..0x48 in order, one per cycle, then ConsoleValid=0.
- Full with simultaneous pop:
  - At count 8, push 0x50 while ConsoleReady=1 -> count stays 8, overflow stays 0, and 0x50 emerges last.
- Unmapped access and status clear:
  - Write to IO+0x10 -> ReadData there = 0, STAT bit3=1.
  - Write STAT=32'h8 -> bit3 cleared.
  - A write of LED=32'h12345 -> LEDOut=16'h2345.
